// File: rtl/ad1_sample_scheduler_if.sv
// Bundle between the AD1 sample scheduler and its environment (requesters, flag control, AD1 core).
// master = environment side, slave = scheduler side.
interface ad1_sample_scheduler_if #(
    parameter int PERIOD_WIDTH = 16
);
    logic [PERIOD_WIDTH-1:0] period;
    logic                    req0;
    logic                    req1;
    logic                    ack0;
    logic                    ack1;
    logic                    tick_valid;
    logic [11:0]             sample_ch0;
    logic [11:0]             sample_ch1;
    logic                    overrun;
    logic                    timeout_err;
    logic                    clr_flags;
    logic                    ad_start;
    logic                    ad_done;
    logic [11:0]             ad_ch0;
    logic [11:0]             ad_ch1;

    modport master (
        output period, req0, req1, clr_flags, ad_done, ad_ch0, ad_ch1,
        input  ack0, ack1, tick_valid, sample_ch0, sample_ch1, overrun, timeout_err, ad_start
    );

    modport slave (
        input  period, req0, req1, clr_flags, ad_done, ad_ch0, ad_ch1,
        output ack0, ack1, tick_valid, sample_ch0, sample_ch1, overrun, timeout_err, ad_start
    );
endinterface

// File: rtl/ad1_sample_scheduler.sv
// Shares one Pmod AD1 conversion engine between a periodic timer and two round-robin requesters,
// with a conversion watchdog. Define AD1_SCHED_TIMER_EN to compile in the periodic timer.
module ad1_sample_scheduler #(
    parameter int PERIOD_WIDTH = 16,
    parameter int TIMEOUT      = 1024
) (
    input logic                   clk,
    input logic                   rst,
    ad1_sample_scheduler_if.slave sched_io
);
    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {SRC_P0, SRC_P1, SRC_TMR} src_t;

    state_t          state_q;
    src_t            src_q;
    logic            rr_q;
    logic [WD_W-1:0] wdog_q;
    logic            ad_start_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            tick_valid_q;
    logic [11:0]     smp0_q;
    logic [11:0]     smp1_q;
    logic            timeout_err_q;
    logic            timeout_err_d;
    logic            tick_pend;
    logic            req0_eff;
    logic            req1_eff;
    logic            wd_fire;

    // A requester is not re-granted in its own ack cycle; a held req counts again afterwards.
    assign req0_eff = sched_io.req0 & ~ack0_q;
    assign req1_eff = sched_io.req1 & ~ack1_q;
    assign wd_fire  = (state_q == WAIT) && !sched_io.ad_done && ((wdog_q + WD_W'(1)) == WD_LAST);

`ifdef AD1_SCHED_TIMER_EN
    logic [PERIOD_WIDTH-1:0] tcnt_q;
    logic [PERIOD_WIDTH-1:0] tcnt_d;
    logic                    tpend_q;
    logic                    tpend_d;
    logic                    overrun_q;
    logic                    overrun_d;
    logic                    wrap;
    logic                    ovr_set;
    logic                    tmr_done;

    assign tmr_done = (state_q == WAIT) && sched_io.ad_done && (src_q == SRC_TMR);

    // Counter above a newly lowered period wraps on the next cycle.
    always_comb begin
        tcnt_d = tcnt_q + PERIOD_WIDTH'(1);
        wrap   = 1'b0;
        if (sched_io.period == '0) begin
            tcnt_d = '0;
        end else if (tcnt_q >= (sched_io.period - PERIOD_WIDTH'(1))) begin
            tcnt_d = '0;
            wrap   = 1'b1;
        end
    end

    always_comb begin
        tpend_d = tpend_q;
        ovr_set = 1'b0;
        if (tmr_done) begin
            tpend_d = 1'b0;
        end
        if (wrap) begin
            if (tpend_q && !tmr_done) begin
                ovr_set = 1'b1;
            end else begin
                tpend_d = 1'b1;
            end
        end
        overrun_d = sched_io.clr_flags ? 1'b0 : (overrun_q | ovr_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q    <= '0;
            tpend_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            tpend_q   <= tpend_d;
            overrun_q <= overrun_d;
        end
    end

    assign tick_pend        = tpend_q;
    assign sched_io.overrun = overrun_q;
`else
    logic unused_period;
    assign unused_period    = ^sched_io.period;
    assign tick_pend        = 1'b0;
    assign sched_io.overrun = 1'b0;
`endif

    assign timeout_err_d = sched_io.clr_flags ? 1'b0 : (timeout_err_q | wd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= SRC_P0;
            rr_q         <= 1'b1;
            wdog_q       <= '0;
            ad_start_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tick_valid_q <= 1'b0;
            smp0_q       <= '0;
            smp1_q       <= '0;
        end else begin
            ad_start_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tick_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // rr_q names the last-served port; the timer never moves it.
                    if (tick_pend) begin
                        src_q      <= SRC_TMR;
                        ad_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else if (req0_eff && (!req1_eff || rr_q)) begin
                        src_q      <= SRC_P0;
                        ad_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end else if (req1_eff) begin
                        src_q      <= SRC_P1;
                        ad_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (sched_io.ad_done) begin
                        smp0_q  <= sched_io.ad_ch0;
                        smp1_q  <= sched_io.ad_ch1;
                        state_q <= IDLE;
                        case (src_q)
                            SRC_P0: begin
                                ack0_q <= 1'b1;
                                rr_q   <= 1'b0;
                            end
                            SRC_P1: begin
                                ack1_q <= 1'b1;
                                rr_q   <= 1'b1;
                            end
                            default: tick_valid_q <= 1'b1;
                        endcase
                    end else if (wd_fire) begin
                        // Source stays pending and is re-arbitrated from IDLE.
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sched_io.ad_start    = ad_start_q;
    assign sched_io.ack0        = ack0_q;
    assign sched_io.ack1        = ack1_q;
    assign sched_io.tick_valid  = tick_valid_q;
    assign sched_io.sample_ch0  = smp0_q;
    assign sched_io.sample_ch1  = smp1_q;
    assign sched_io.timeout_err = timeout_err_q;
endmodule
